dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
- Sits between the MIPS core's data port and a multi-cycle data memory that uses a req/ready handshake.
- Read hits return data combinationally with no stall. Read misses and all writes stall the core until the memory handshake completes.
- Provides saturating read-hit and read-miss counters for performance measurement.

Parameters:
- INDEX_BITS, 4, log2 of the number of lines (16 lines by default). Tag width is 30-INDEX_BITS.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_re  in  1  core read request.
- cpu_we  in  1  core write request; has priority over cpu_re.
- cpu_addr  in  32  byte address; bits [1:0] are ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  freezes the core while high.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable; qualified by mem_req.
- mem_addr  out  32  word-aligned address, {cpu_addr[31:2],2'b00}.
- mem_wdata  out  32  memory store data.
- mem_rdata  in  32  memory load data; valid when mem_ready is high.
- mem_ready  in  1  one-cycle completion pulse from memory.
- hit_count  out  CNT_W  saturating count of read hits.
- miss_count  out  CNT_W  saturating count of read misses.

Behaviour:
- Address split:
  - index = cpu_addr[INDEX_BITS+1:2]
  - tag = cpu_addr[31:INDEX_BITS+2]
  - hit = valid[index] && tag_array[index]==tag
- Storage: valid bits, tag array and data array. Only valid and the counters are reset. Tag and data contents are don't-care until a line is filled.
- Reset (asynchronous), applied immediately:
  - all valid bits cleared
  - state = IDLE
  - mem_req=0, mem_we=0, cpu_stall=0
  - hit_count=0, miss_count=0
  - cpu_rdata = 0 while no read hit is present
  - Reset during FETCH or WRITE aborts the transaction. No line is updated. Any later mem_ready is ignored.
- State IDLE:
  - cpu_we=1: cpu_stall=1 combinationally, go to WRITE next edge.
  - cpu_re=1 and hit: cpu_rdata = data[index], cpu_stall=0, hit_count++. Stay in IDLE.
  - cpu_re=1 and miss: cpu_stall=1 combinationally, miss_count++, go to FETCH next edge.
  - No request: cpu_stall=0, mem_req=0.
- State FETCH:
  - mem_req=1, mem_we=0, cpu_stall=1.
  - On the edge where mem_ready=1: write tag, data=mem_rdata and valid=1 at index, then return to IDLE.
  - The next cycle sees a hit and deasserts the stall; this hit also increments hit_count.
  - Read-miss penalty = memory latency + 1 cycle.
- State WRITE:
  - mem_req=1, mem_we=1, mem_wdata=cpu_wdata, cpu_stall=1.
  - On mem_ready: if hit, data[index]=cpu_wdata (valid and tag unchanged). If miss, nothing is allocated. Return to IDLE.
  - cpu_stall stays high in the mem_ready cycle and drops in the following IDLE cycle.
  - The core holds cpu_we high for the whole stall, so the write has been committed once it is accepted. The FSM returns to IDLE and needs one extra edge to see the core's next instruction. To avoid a duplicate write, a one-cycle DONE state follows WRITE: stall=0, mem_req=0, and any request in this cycle is ignored.
- Core contract: cpu_addr, cpu_we, cpu_re and cpu_wdata are held stable while cpu_stall=1.
- Memory contract:
  - mem_req stays high with stable address and data until mem_ready is sampled high.
  - mem_ready is ignored whenever mem_req=0.
  - A zero-wait memory (mem_ready high in the first request cycle) is supported.
- Counters: saturate at all-ones and never wrap. Writes are not counted.
- Simultaneous cpu_re and cpu_we: treated as a write and counted by neither counter.

Test Plan:
- Reset, then read 0x0000_0040 with memory latency 3 and mem_rdata=0xDEADBEEF -> stall held 4 cycles, mem_addr=0x40 with mem_we=0, then cpu_rdata=0xDEADBEEF with stall=0; miss_count=1, hit_count=1.
- Repeat the read of 0x40 -> no stall, no mem_req, data 0xDEADBEEF, hit_count=2.
- Read 0x0000_0440 (same index, different tag) -> miss and refill. A subsequent read of 0x40 misses again.
- Write 0x12345678 to cached 0x40 -> mem_we=1 with mem_wdata=0x12345678 until ready. A following read of 0x40 hits with 0x12345678.
- Write to uncached 0x80, then read 0x80 -> the write goes to memory and the read misses (no allocate). Exactly one memory write is issued.
- Assert reset mid-FETCH with mem_ready arriving afterwards -> mem_req=0 immediately, counters=0, a read of the same address misses; also drive 70000 hits and confirm hit_count saturates at 0xFFFF.

Source files
------------

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through no-write-allocate data cache
//
// Purpose: one-word-line data cache between the core data port and a
// multi-cycle req/ready data memory. Read hits answer combinationally.
// Read misses and all writes stall the core until memory completes.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   cpu_re, cpu_we        core read / write request (write wins)
//   cpu_addr, cpu_wdata   core byte address (bits [1:0] ignored), store data
//   cpu_rdata, cpu_stall  load data (0 unless read hit), core freeze
//   mem_req, mem_we       memory request, write enable
//   mem_addr, mem_wdata   word-aligned memory address, store data
//   mem_rdata, mem_ready  memory load data, one-cycle completion pulse
//   hit_count, miss_count saturating read-hit / read-miss counters
module dcache_wt #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   index;
  logic [TAG_W-1:0]        tag;
  logic                    hit;
  logic                    rd_req;
  logic                    in_idle;
  logic                    fill;
  logic                    wr_update;
  logic                    unused_addr_bits;

  assign index   = cpu_addr[INDEX_BITS+1:2];
  assign tag     = cpu_addr[31:INDEX_BITS+2];
  assign hit     = valid[index] && (tag_mem[index] == tag);
  assign rd_req  = cpu_re && !cpu_we;
  assign in_idle = (state == IDLE);

  assign unused_addr_bits = ^cpu_addr[1:0];

  // Stall is raised in the same cycle a miss or write is seen so the core
  // never advances past it; reset forces it low even with a request pending.
  assign cpu_stall = !reset &&
                     ((in_idle && (cpu_we || (rd_req && !hit))) ||
                      (state == FETCH) || (state == WRITE));

  assign cpu_rdata = (in_idle && rd_req && hit) ? data_mem[index] : 32'h0;
  assign mem_addr  = {cpu_addr[31:2], 2'b00};
  assign mem_wdata = cpu_wdata;

  assign fill      = (state == FETCH) && mem_ready;
  assign wr_update = (state == WRITE) && mem_ready && hit;

  // Tag and data arrays carry no reset; valid alone marks their contents.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= mem_rdata;
    end else if (wr_update) begin
      data_mem[index] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_we) begin
            state   <= WRITE;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end else if (cpu_re) begin
            if (hit) begin
              if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
            end else begin
              if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
              state   <= FETCH;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (mem_ready) begin
            valid[index] <= 1'b1;
            state        <= IDLE;
            mem_req      <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        // The core still presents the write it just retired; swallow it.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// tb/tb_dcache_wt.sv - randomized self-checking bench for dcache_wt
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_count, miss_count;

  dcache_wt #(.INDEX_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: cache contents, backing memory, event counts.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] mem_model [bit [31:0]];
  int          n_hit, n_miss;

  // Expected outputs for the current cycle.
  bit          chk = 1'b0;
  logic        e_stall, e_req, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;

  int stall_cycles = 0;
  int wr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  always @(negedge clk) begin
    if (chk && !reset) begin
      check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      check("mem_req", 32'(mem_req), 32'(e_req));
      if (e_req) begin
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
      end
      check("cpu_rdata", cpu_rdata, e_rdata);
      check("hit_count", 32'(hit_count), 32'(sat(n_hit)));
      check("miss_count", 32'(miss_count), 32'(sat(n_miss)));
    end
  end

  always @(negedge clk) if (cpu_stall) stall_cycles++;
  always @(posedge clk) if (mem_req && mem_we && mem_ready) wr_seen++;

  // One core operation; entered just after a rising edge, returns just after
  // the edge that ends it. lat = request cycles until mem_ready (1 = zero-wait).
  task automatic do_op(input bit we, input bit re, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat);
    logic [3:0]  idx;
    logic [25:0] tg;
    logic [31:0] wa;
    bit          is_hit;
    idx = addr[5:2];
    tg  = addr[31:6];
    wa  = {addr[31:2], 2'b00};
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
    mem_ready = 1'($urandom);   // stray pulse outside a request must be ignored
    mem_rdata = $urandom;
    e_req = 1'b0; e_we = 1'b0;
    if (we) begin
      e_stall = 1'b1; e_rdata = 32'h0;
      @(posedge clk);
      for (int k = 1; k <= lat; k++) begin
        #1;
        e_stall = 1'b1; e_req = 1'b1; e_we = 1'b1; e_addr = wa; e_wdata = wdata; e_rdata = 32'h0;
        mem_ready = (k == lat); mem_rdata = $urandom;
        @(posedge clk);
      end
      mem_model[wa] = wdata;
      if (m_valid[idx] && m_tag[idx] == tg) m_data[idx] = wdata;
      #1;
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_rdata = 32'h0;
      mem_ready = 1'($urandom);
      @(posedge clk);
    end else if (re) begin
      is_hit = m_valid[idx] && (m_tag[idx] == tg);
      if (!is_hit) begin
        e_stall = 1'b1; e_rdata = 32'h0;
        @(posedge clk);
        n_miss++;
        for (int k = 1; k <= lat; k++) begin
          #1;
          e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = wa; e_rdata = 32'h0;
          mem_ready = (k == lat);
          mem_rdata = (k == lat) ? memval(wa) : $urandom;
          @(posedge clk);
        end
        m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = memval(wa);
        #1;
        e_req = 1'b0;
        mem_ready = 1'($urandom); mem_rdata = $urandom;
      end
      e_stall = 1'b0; e_rdata = m_data[idx];
      @(posedge clk);
      n_hit++;
    end else begin
      e_stall = 1'b0; e_rdata = 32'h0;
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    int wr0;
    int r;
    logic [31:0] a;
    reset = 1'b1;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    n_hit = 0; n_miss = 0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(cpu_stall), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_hit_count", 32'(hit_count), 32'h0);
    check("rst_miss_count", 32'(miss_count), 32'h0);
    cpu_re = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk = 1'b1;

    mem_model[32'h40]  = 32'hDEADBEEF;
    mem_model[32'h440] = 32'h0BADF00D;

    stall_cycles = 0;
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 3);
    check("lit_miss_stall_cycles", 32'(stall_cycles), 32'd4);
    check("lit_first_hit_count", 32'(hit_count), 32'd1);
    check("lit_first_miss_count", 32'(miss_count), 32'd1);

    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; #1;
    check("lit_hit_rdata", cpu_rdata, 32'hDEADBEEF);
    check("lit_hit_stall", 32'(cpu_stall), 32'h0);
    check("lit_hit_mem_req", 32'(mem_req), 32'h0);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 1);
    check("lit_hit_count_2", 32'(hit_count), 32'd2);

    do_op(1'b0, 1'b1, 32'h440, 32'h0, 2);
    check("lit_conflict_miss", 32'(miss_count), 32'd2);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 1);
    check("lit_evicted_miss", 32'(miss_count), 32'd3);

    do_op(1'b1, 1'b0, 32'h40, 32'h12345678, 2);
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; #1;
    check("lit_write_hit_update", cpu_rdata, 32'h12345678);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 1);

    wr0 = wr_seen;
    do_op(1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 3);
    do_op(1'b0, 1'b1, 32'h80, 32'h0, 2);
    check("lit_one_mem_write", 32'(wr_seen - wr0), 32'd1);
    check("lit_no_allocate_miss", 32'(miss_count), 32'd4);
    check("lit_hit_count_6", 32'(hit_count), 32'd6);

    // Reset in the middle of a fetch, with a late mem_ready afterwards.
    chk = 1'b0;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("fetch_req_before_reset", 32'(mem_req), 32'h1);
    reset = 1'b1;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'h0);
    check("abort_stall", 32'(cpu_stall), 32'h0);
    check("abort_hit_count", 32'(hit_count), 32'h0);
    check("abort_miss_count", 32'(miss_count), 32'h0);
    cpu_re = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11112222;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    n_hit = 0; n_miss = 0;
    chk = 1'b1;
    do_op(1'b0, 1'b1, 32'h100, 32'h0, 2);
    check("lit_after_abort_miss", 32'(miss_count), 32'd1);

    for (int n = 0; n < 400; n++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 99);
      if (r < 50)      do_op(1'b0, 1'b1, a, 32'h0, $urandom_range(1, 4));
      else if (r < 75) do_op(1'b1, 1'b0, a, $urandom, $urandom_range(1, 4));
      else if (r < 85) do_op(1'b1, 1'b1, a, $urandom, $urandom_range(1, 4));
      else             do_op(1'b0, 1'b0, a, 32'h0, 1);
    end

    do_op(1'b0, 1'b1, 32'h40, 32'h0, 1);
    repeat (70000) do_op(1'b0, 1'b1, 32'h40, 32'h0, 1);
    check("lit_hit_saturated", 32'(hit_count), 32'h0000FFFF);

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
